// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Debug reader for the MIPS register file. A start request in IDLE walks the
// read address from FIRST_REG to LAST_REG through a spare combinational read
// port. Each {addr, data} pair is presented as one beat on a valid/ready
// stream toward the debug/trace path. The block only reads; it never writes
// the register file.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   synchronous, active-high reset
//   start      in   dump request, sampled only in IDLE
//   busy       out  high while a dump is in progress (FETCH or SEND)
//   done       out  one-cycle pulse after the last beat is accepted
//   rd_addr    out  register-file read address (current walk index)
//   rd_data    in   combinational read data for rd_addr
//   out_valid  out  beat available
//   out_ready  in   consumer accepts the beat when out_valid && out_ready
//   out_addr   out  register index of the current beat
//   out_data   out  register value of the current beat
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_DONE
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   idx_q,       idx_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;

  // Next-state and datapath logic.
  // NOTE: every _d signal takes its hold value first, so no path through the
  // case statement leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // Capture the value read this cycle; a write landing on the same
        // edge is therefore not reflected in this beat.
        out_data_d  = rd_data;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        // Beat holds (addr/data unchanged) until the consumer takes it.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        // Park the read address back on the first register for IDLE.
        idx_d   = FIRST_IDX;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-dump abandons the
  // walk without emitting further beats or a done pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= FIRST_IDX;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = (state_q == ST_FETCH) || (state_q == ST_SEND);
  assign done      = (state_q == ST_DONE);
  assign rd_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Directed bench for regfile_dump_reader. A behavioural 32x32 register file
// feeds the read ports. One instance dumps the full file (0..31); a second
// instance is built with FIRST_REG = LAST_REG = 9. Outputs are sampled and
// inputs driven on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;

  // Full-range instance.
  logic        start;
  logic        busy, done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;

  // Single-register instance.
  logic        start9;
  logic        busy9, done9;
  logic [4:0]  rd_addr9;
  logic [31:0] rd_data9;
  logic        out_valid9, out_ready9;
  logic [4:0]  out_addr9;
  logic [31:0] out_data9;

  logic [31:0] regs [32];
  bit          wrote20 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rd_data  = regs[rd_addr];
  assign rd_data9 = regs[rd_addr9];

  regfile_dump_reader #(
    .ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  regfile_dump_reader #(
    .ADDR_W(5), .DATA_W(32), .FIRST_REG(9), .LAST_REG(9)
  ) u_dut9 (
    .clk(clk), .reset(reset), .start(start9), .busy(busy9), .done(done9),
    .rd_addr(rd_addr9), .rd_data(rd_data9), .out_valid(out_valid9),
    .out_ready(out_ready9), .out_addr(out_addr9), .out_data(out_data9)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-derived register contents: preload pattern, plus the one mid-dump write.
  function automatic logic [31:0] exp_data(input int a);
    if (wrote20 && a == 20) return 32'hDEAD_BEEF;
    return 32'hA000_0000 + a;
  endfunction

  // Runs one full dump of u_dut from a start pulse. Optional knobs (-1 = off):
  // stall a beat for stall_len cycles, pulse start again during a beat, and
  // write reg[20] while a given beat is presented.
  task automatic dump_run(input string name, input int stall_beat, input int stall_len,
                          input int restart_beat, input int write_beat,
                          input int exp_done_cyc);
    int cyc;
    int beats;
    int stalls;
    int done_cyc;
    beats    = 0;
    stalls   = 0;
    done_cyc = -1;
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);            // start sampled on the edge just passed
    start = 1'b0;
    cyc   = 1;
    check({name, "_c1_busy"}, busy, 1);
    check({name, "_c1_valid"}, out_valid, 0);
    check({name, "_c1_rdaddr"}, rd_addr, 0);
    while (cyc <= 300 && done_cyc < 0) begin
      if (done) begin
        done_cyc = cyc;
        check({name, "_done_busy"}, busy, 0);
        check({name, "_done_valid"}, out_valid, 0);
      end else if (out_valid) begin
        if (int'(out_addr) == stall_beat && stalls < stall_len) begin
          out_ready = 1'b0;
          stalls++;
          check({name, "_stall_addr"}, out_addr, stall_beat);
          check({name, "_stall_data"}, out_data, exp_data(stall_beat));
        end else begin
          out_ready = 1'b1;
          check({name, "_beat_addr"}, out_addr, beats);
          check({name, "_beat_data"}, out_data, exp_data(beats));
          beats++;
        end
        check({name, "_send_busy"}, busy, 1);
        start = (int'(out_addr) == restart_beat);
        if (int'(out_addr) == write_beat && !wrote20) begin
          regs[20] = 32'hDEAD_BEEF;
          wrote20  = 1'b1;
        end
      end else begin
        check({name, "_fetch_busy"}, busy, 1);
        out_ready = 1'b1;
        start     = 1'b0;
      end
      if (done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({name, "_done_cycle"}, done_cyc, exp_done_cyc);
    check({name, "_beats"}, beats, 32);
    if (stall_beat >= 0) check({name, "_stalls"}, stalls, stall_len);
    // Back in IDLE: single done pulse, no restart, read address parked.
    @(negedge clk);
    check({name, "_post_done"}, done, 0);
    check({name, "_post_busy"}, busy, 0);
    check({name, "_post_rdaddr"}, rd_addr, 0);
    @(negedge clk);
    check({name, "_post2_done"}, done, 0);
    check({name, "_post2_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
    reset      = 1'b1;
    start      = 1'b0;
    start9     = 1'b0;
    out_ready  = 1'b0;
    out_ready9 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_addr9", rd_addr9, 9);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // 1: plain dump, out_ready held high.
    dump_run("t1", -1, 0, -1, -1, 65);

    // 2: backpressure on beat 3 for 5 cycles.
    dump_run("t2", 3, 5, -1, -1, 70);

    // 3: second start during beat 10 must be ignored.
    dump_run("t3", -1, 0, 10, -1, 65);

    // 4: reset during beat 7, then a fresh dump from beat 0.
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_addr == 5'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_beat7", out_addr, 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_rd_addr", rd_addr, 0);
    @(negedge clk);
    check("t4_done2", done, 0);
    check("t4_busy2", busy, 0);
    dump_run("t4b", -1, 0, -1, -1, 65);

    // 6: FIRST_REG = LAST_REG = 9 instance.
    start9 = 1'b1;
    @(negedge clk);
    start9 = 1'b0;
    check("t6_fetch_busy", busy9, 1);
    check("t6_fetch_valid", out_valid9, 0);
    check("t6_fetch_rdaddr", rd_addr9, 9);
    @(negedge clk);
    check("t6_valid", out_valid9, 1);
    check("t6_addr", out_addr9, 9);
    check("t6_data", out_data9, 32'hA000_0009);
    @(negedge clk);
    check("t6_done", done9, 1);
    check("t6_done_busy", busy9, 0);
    check("t6_done_valid", out_valid9, 0);
    @(negedge clk);
    check("t6_post_done", done9, 0);
    check("t6_post_valid", out_valid9, 0);

    // 5: write reg[20] during beat 5; beat 20 must carry the new value.
    dump_run("t5", -1, 0, -1, 5, 65);
    check("t5_wrote", wrote20, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
